program_counter: RTL and testbench
==================================

Name: program_counter

Overview:
- Hack-platform program counter: a WIDTH-bit register that holds the address of the next instruction.
- Sits directly downstream of the gate library. Its next-state logic (incrementer, 2:1 word muxes, priority select) is composed from the NAND-derived gate modules. The state register is the only behavioural primitive.
- Its output feeds the instruction-memory address port; the CPU drives `load`/`in` for jumps.

Parameters:
- WIDTH, 16, data/address width in bits (≥2).
- RESET_VALUE, 0, value loaded on reset (WIDTH bits).

Ports:
- clk  input  1  single rising-edge clock
- reset  input  1  synchronous, active-high reset
- in  input  WIDTH  jump target, sampled when load=1
- load  input  1  load `in` on next edge
- inc  input  1  increment on next edge
- out  output  WIDTH  current PC value, registered

Behaviour:
- Clocking: one clock (`clk`). Reset is synchronous and active-high (`reset`). All state changes happen only on the rising edge of `clk`.
- Reset value: `out` = RESET_VALUE (0x0000) after any edge with reset=1. Before the first reset, `out` is X. The bench must reset first.
- Next-state priority, evaluated at each rising edge:
  - reset=1 → out ← RESET_VALUE
  - else load=1 → out ← in
  - else inc=1 → out ← out+1
  - else out ← out (hold)
- Simultaneous controls: the higher-priority control wins. load+inc → loads `in` with no increment. reset+load → RESET_VALUE.
- Latency: a control or data change is visible on `out` one cycle after the edge that samples it. `out` never changes combinationally from inputs.
- Arithmetic: unsigned, modulo 2^WIDTH. 0xFFFF + 1 → 0x0000 with no carry-out or flag. The carry from the MSB is discarded.
- Load width: `in` is taken verbatim, with no sign or zero extension.
- Reset mid-operation: a reset during an increment run forces RESET_VALUE at that edge. Counting resumes from RESET_VALUE on the next edge with inc=1 and reset=0.
- State: implicit 2-mode control (HOLD vs UPDATE) selected per cycle by the priority chain above. There is no multi-cycle state and no internal pipeline.
- Glitch rule: the next-state mux chain order is inc-mux, then load-mux, then reset-mux, nearest the register. This makes the priority structural.
- X-handling: if `in` is X while load=0, `out` must not go X.

Decomposition:
- Shared constants header (`hack_defs.vh`): WORD_WIDTH=16, ZERO_WORD=16'h0000, ONE_WORD=16'h0001.
- Include-guard the header so multiple inclusion through the gate chain is safe.
- Natural sub-module: `inc16`, a WIDTH-bit incrementer built as a half-adder ripple chain from the existing gate modules.
- Word muxes reuse the existing 16-bit mux gate. The register is a WIDTH-bit DFF bank instantiated in `program_counter`.

Test Plan:
- Reset, then inc=1 for 5 cycles → out sequence 0,1,2,3,4,5. Then inc=0 for 3 cycles → out holds 5.
- From out=0x0010, load=1, in=0x1234, inc=1 in the same cycle → out=0x1234 next cycle, not 0x0011. The following cycle with inc=1 only → 0x1235.
- load=1, in=0xFFFE, then inc=1 for 3 cycles → 0xFFFE, 0xFFFF, 0x0000, 0x0001. No X appears on out.
- Counting at 0x0042 with inc=1, assert reset=1 and load=1 with in=0x7777 for one cycle → out=0x0000. Next cycle with inc=1 → 0x0001.
- Hold with in toggling randomly and load=0, inc=0 for 8 cycles → out constant. Separately, a reset pulse between clock edges with no edge during the pulse → out unchanged (confirms synchronous reset).

Source files
------------

// File: rtl/program_counter_pkg.sv
// Shared Hack-platform word constants used by the program counter and its incrementer.
package program_counter_pkg;

    localparam int          WORD_WIDTH = 16;
    localparam logic [15:0] ZERO_WORD  = 16'h0000;
    localparam logic [15:0] ONE_WORD   = 16'h0001;

    // Single-bit half adder; the incrementer ripples a chain of these.
    function automatic logic [1:0] half_add(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

endpackage

// File: rtl/program_counter_inc16.sv
// WIDTH-bit incrementer built as a ripple chain of half adders; MSB carry is dropped.
module program_counter_inc16
    import program_counter_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] carry;

    // The chain's carry-in is the low bit of ONE_WORD, i.e. a constant +1.
    assign carry[0] = ONE_WORD[0];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ha
            logic [1:0] ha;
            assign ha      = half_add(a[gi], carry[gi]);
            assign sum[gi] = ha[0];
            if (gi < WIDTH - 1) begin : g_carry
                assign carry[gi+1] = ha[1];
            end
        end
    endgenerate

endmodule

// File: rtl/program_counter.sv
// Hack program counter: reset > load > inc > hold, one register, next-state built as a mux chain.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int               WIDTH       = WORD_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(ZERO_WORD)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] inc_mux;
    logic [WIDTH-1:0] load_mux;

    program_counter_inc16 #(
        .WIDTH (WIDTH)
    ) u_inc (
        .a   (out_reg),
        .sum (inc_val)
    );

    // Mux order inc -> load -> reset makes the priority structural; `in` is
    // only steered toward the register when load=1, so an X on it is harmless otherwise.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mux
            assign inc_mux[gi]  = inc  ? inc_val[gi] : out_reg[gi];
            assign load_mux[gi] = load ? in[gi]      : inc_mux[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg <= RESET_VALUE;
        end else begin
            out_reg <= load_mux;
        end
    end

    assign out = out_reg;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios plus randomized traffic vs. a priority model.
module tb_program_counter;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic [W-1:0] in;
    logic         load;
    logic         inc;
    logic [W-1:0] out;

    int           vectors;
    int           miscompares;
    logic [W-1:0] model;
    int           cyc;

    program_counter #(
        .WIDTH       (W),
        .RESET_VALUE (16'h0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .load  (load),
        .inc   (inc),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference next-state: reset first, then load, then increment modulo 2^W, else hold.
    function automatic logic [W-1:0] ref_next(input logic [W-1:0] cur, input logic r,
                                              input logic l, input logic i,
                                              input logic [W-1:0] d);
        int unsigned nxt;
        if (r) return '0;
        if (l) return d;
        if (i) begin
            nxt = (int'(cur) + 1) % (1 << W);
            return W'(nxt);
        end
        return cur;
    endfunction

    // Advances one clock with the currently driven inputs; outputs are sampled 1ns after the edge.
    task automatic tick();
        logic [W-1:0] expect_val;
        expect_val = ref_next(model, reset, load, inc, in);
        @(posedge clk);
        #1;
        model = expect_val;
        cyc++;
        $display("cyc %0d reset=%0b load=%0b inc=%0b in=%h out=%h model=%h",
                 cyc, reset, load, inc, in, out, model);
    endtask

    task automatic drive(input logic r, input logic l, input logic i, input logic [W-1:0] d);
        reset = r;
        load  = l;
        inc   = i;
        in    = d;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 16'hABCD);
        tick();
        vectors++;
        if (out !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_value: out=%h required=0000", out);
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        vectors++;
        if (out !== model) begin
            miscompares++;
            $display("FAIL reset_release_hold: out=%h required=%h", out, model);
        end
    endtask

    task automatic test_count_hold();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, 1'b0, 1'b1, W'($urandom));
            tick();
            vectors++;
            if (out !== model || out !== W'(k)) begin
                miscompares++;
                $display("FAIL count_step%0d: out=%h required=%h", k, out, W'(k));
            end
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, W'($urandom));
            tick();
            vectors++;
            if (out !== 16'h0005) begin
                miscompares++;
                $display("FAIL count_hold%0d: out=%h required=0005", k, out);
            end
        end
    endtask

    task automatic test_load_priority();
        drive(1'b0, 1'b1, 1'b0, 16'h0010);
        tick();
        drive(1'b0, 1'b1, 1'b1, 16'h1234);
        tick();
        vectors++;
        if (out !== 16'h1234) begin
            miscompares++;
            $display("FAIL load_over_inc: out=%h required=1234", out);
        end
        drive(1'b0, 1'b0, 1'b1, 16'h5555);
        tick();
        vectors++;
        if (out !== 16'h1235) begin
            miscompares++;
            $display("FAIL inc_after_load: out=%h required=1235", out);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] seq [4];
        seq[0] = 16'hFFFE;
        seq[1] = 16'hFFFF;
        seq[2] = 16'h0000;
        seq[3] = 16'h0001;
        drive(1'b0, 1'b1, 1'b0, 16'hFFFE);
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (out !== seq[k] || out !== model) begin
                miscompares++;
                $display("FAIL wrap%0d: out=%h required=%h", k, out, seq[k]);
            end
            drive(1'b0, 1'b0, 1'b1, W'($urandom));
        end
    endtask

    task automatic test_reset_priority();
        drive(1'b0, 1'b1, 1'b0, 16'h0041);
        tick();
        drive(1'b0, 1'b0, 1'b1, 16'h0000);
        tick();
        vectors++;
        if (out !== 16'h0042) begin
            miscompares++;
            $display("FAIL pre_reset_count: out=%h required=0042", out);
        end
        drive(1'b1, 1'b1, 1'b1, 16'h7777);
        tick();
        vectors++;
        if (out !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_over_load: out=%h required=0000", out);
        end
        drive(1'b0, 1'b0, 1'b1, 16'h7777);
        tick();
        vectors++;
        if (out !== 16'h0001) begin
            miscompares++;
            $display("FAIL count_after_reset: out=%h required=0001", out);
        end
    endtask

    task automatic test_hold_random_in();
        logic [W-1:0] held;
        drive(1'b0, 1'b1, 1'b0, 16'h3C5A);
        tick();
        held = model;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b0, 1'b0, W'($urandom));
            tick();
            vectors++;
            if (out !== held) begin
                miscompares++;
                $display("FAIL hold_in_toggle%0d: out=%h required=%h", k, out, held);
            end
        end
    endtask

    task automatic test_sync_reset_glitch();
        logic [W-1:0] held;
        held = model;
        // Pulse reset entirely between edges; a synchronous reset must ignore it.
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (out !== held) begin
            miscompares++;
            $display("FAIL glitch_between_edges: out=%h required=%h", out, held);
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        vectors++;
        if (out !== held) begin
            miscompares++;
            $display("FAIL glitch_after_edge: out=%h required=%h", out, held);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) != 0, W'($urandom));
            // Occasionally steer the counter near the wrap point.
            if (load && $urandom_range(0, 3) == 0) in = 16'hFFFF - W'($urandom_range(0, 3));
            tick();
            vectors++;
            if (out !== model) begin
                miscompares++;
                $display("FAIL random%0d: out=%h required=%h", k, out, model);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model       = '0;
        cyc         = 0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        test_reset();
        test_count_hold();
        test_load_priority();
        test_wrap();
        test_reset_priority();
        test_hold_random_in();
        test_sync_reset_glitch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
